// File: rtl/spi_flash_responder.sv
// SPI mode-0 responder emulating the 0xAB / 0x03 subset of a NOR flash.
// Bytes are served from an external byte-wide read port with one-cycle latency.
module spi_flash_responder #(
  parameter bit          START_AWAKE = 1'b1,
  parameter bit          IDLE_MISO   = 1'b1,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        spi_cs,
  input  logic        spi_sclk,
  input  logic        spi_mosi,
  output logic        spi_miso,
  output logic        mem_rd,
  output logic [23:0] mem_addr,
  input  logic [7:0]  mem_data,
  output logic        awake,
  output logic        reading
);

  localparam int unsigned AddrW = 24;
  localparam int unsigned ByteW = 8;
  localparam int unsigned CntW  = 5;
  localparam int unsigned SyncN = (SYNC_STAGES < 2) ? 2 : SYNC_STAGES;

  localparam logic [ByteW-1:0] CmdRelease = 8'hAB;
  localparam logic [ByteW-1:0] CmdRead    = 8'h03;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CMD,
    ST_ADDR,
    ST_DATA,
    ST_IGNORE
  } state_e;

  // Synchronizers reset to 0 so a cs already low at reset release is not a falling edge.
  logic [SyncN-1:0] cs_sync_q, sclk_sync_q, mosi_sync_q;
  logic             cs_prev_q, sclk_prev_q;
  logic             cs_s, sclk_s, mosi_s;
  logic             cs_fall, sclk_rise, sclk_fall;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cs_sync_q   <= '0;
      sclk_sync_q <= '0;
      mosi_sync_q <= '0;
      cs_prev_q   <= 1'b0;
      sclk_prev_q <= 1'b0;
    end else begin
      cs_sync_q   <= {cs_sync_q[SyncN-2:0], spi_cs};
      sclk_sync_q <= {sclk_sync_q[SyncN-2:0], spi_sclk};
      mosi_sync_q <= {mosi_sync_q[SyncN-2:0], spi_mosi};
      cs_prev_q   <= cs_s;
      sclk_prev_q <= sclk_s;
    end
  end

  assign cs_s      = cs_sync_q[SyncN-1];
  assign sclk_s    = sclk_sync_q[SyncN-1];
  assign mosi_s    = mosi_sync_q[SyncN-1];
  assign cs_fall   = cs_prev_q & ~cs_s;
  assign sclk_rise = sclk_s & ~sclk_prev_q;
  assign sclk_fall = ~sclk_s & sclk_prev_q;

  state_e           state_q, state_d;
  logic [CntW-1:0]  bit_cnt_q, bit_cnt_d;
  logic [AddrW-2:0] shift_q, shift_d;
  logic [ByteW-1:0] tx_q, tx_d;
  logic [ByteW-1:0] hold_q, hold_d;
  logic [2:0]       tx_cnt_q, tx_cnt_d;
  logic             first_q, first_d;
  logic             cap_q, cap_d;
  logic             miso_q, miso_d;
  logic             mem_rd_q, mem_rd_d;
  logic [AddrW-1:0] mem_addr_q, mem_addr_d;
  logic             awake_q, awake_d;
  logic             reading_q, reading_d;

  logic [ByteW-1:0] cmd_byte;
  logic [AddrW-1:0] addr_next;
  logic [ByteW-1:0] tx_src;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= ST_IDLE;
      bit_cnt_q  <= '0;
      shift_q    <= '0;
      tx_q       <= '0;
      hold_q     <= '0;
      tx_cnt_q   <= '0;
      first_q    <= 1'b0;
      cap_q      <= 1'b0;
      miso_q     <= IDLE_MISO;
      mem_rd_q   <= 1'b0;
      mem_addr_q <= '0;
      awake_q    <= START_AWAKE;
      reading_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      bit_cnt_q  <= bit_cnt_d;
      shift_q    <= shift_d;
      tx_q       <= tx_d;
      hold_q     <= hold_d;
      tx_cnt_q   <= tx_cnt_d;
      first_q    <= first_d;
      cap_q      <= cap_d;
      miso_q     <= miso_d;
      mem_rd_q   <= mem_rd_d;
      mem_addr_q <= mem_addr_d;
      awake_q    <= awake_d;
      reading_q  <= reading_d;
    end
  end

  assign cmd_byte  = {shift_q[ByteW-2:0], mosi_s};
  assign addr_next = {shift_q, mosi_s};
  // The first byte of a burst lives in tx_q; later bytes come from the prefetch register.
  assign tx_src    = first_q ? tx_q : hold_q;

  always_comb begin
    state_d    = state_q;
    bit_cnt_d  = bit_cnt_q;
    shift_d    = shift_q;
    tx_d       = tx_q;
    hold_d     = hold_q;
    tx_cnt_d   = tx_cnt_q;
    first_d    = first_q;
    cap_d      = mem_rd_q && (state_q == ST_DATA);
    miso_d     = miso_q;
    mem_rd_d   = 1'b0;
    mem_addr_d = mem_addr_q;
    awake_d    = awake_q;

    unique case (state_q)
      ST_IDLE: begin
        miso_d = IDLE_MISO;
        if (cs_fall) begin
          state_d   = ST_CMD;
          bit_cnt_d = '0;
        end
      end
      ST_CMD: begin
        if (sclk_rise) begin
          shift_d   = addr_next[AddrW-2:0];
          bit_cnt_d = bit_cnt_q + CntW'(1);
          if (bit_cnt_q == CntW'(ByteW - 1)) begin
            bit_cnt_d = '0;
            if (cmd_byte == CmdRelease) begin
              awake_d = 1'b1;
              state_d = ST_IGNORE;
            end else if (cmd_byte == CmdRead && awake_q) begin
              state_d = ST_ADDR;
            end else begin
              state_d = ST_IGNORE;
            end
          end
        end
      end
      ST_ADDR: begin
        if (sclk_rise) begin
          shift_d   = addr_next[AddrW-2:0];
          bit_cnt_d = bit_cnt_q + CntW'(1);
          if (bit_cnt_q == CntW'(AddrW - 1)) begin
            mem_addr_d = addr_next;
            mem_rd_d   = 1'b1;
            first_d    = 1'b1;
            tx_cnt_d   = '0;
            state_d    = ST_DATA;
          end
        end
      end
      ST_DATA: begin
        if (cap_q) begin
          if (first_q) tx_d = mem_data;
          else         hold_d = mem_data;
        end
        if (sclk_fall) begin
          if (tx_cnt_q == 3'd0) begin
            // Present a new byte's MSB and prefetch the following byte.
            miso_d     = tx_src[ByteW-1];
            tx_d       = {tx_src[ByteW-2:0], 1'b0};
            first_d    = 1'b0;
            mem_addr_d = mem_addr_q + AddrW'(1);
            mem_rd_d   = 1'b1;
          end else begin
            miso_d = tx_q[ByteW-1];
            tx_d   = {tx_q[ByteW-2:0], 1'b0};
          end
          tx_cnt_d = tx_cnt_q + 3'd1;
        end
      end
      ST_IGNORE: begin
        miso_d = IDLE_MISO;
      end
      default: begin
        state_d = ST_IDLE;
        miso_d  = IDLE_MISO;
      end
    endcase

    // Deselect aborts any transaction; an in-flight fetch is simply never used.
    if (cs_s && state_q != ST_IDLE) begin
      state_d  = ST_IDLE;
      miso_d   = IDLE_MISO;
      mem_rd_d = 1'b0;
    end

    reading_d = (state_d == ST_DATA);
  end

  assign spi_miso = miso_q;
  assign mem_rd   = mem_rd_q;
  assign mem_addr = mem_addr_q;
  assign awake    = awake_q;
  assign reading  = reading_q;

endmodule
